// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_ctrl_pkg
// Brief    : Command opcodes and sequencer state encoding for counter_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package counter_ctrl_pkg;

    localparam logic [1:0] OP_CLEAR     = 2'b00;
    localparam logic [1:0] OP_UP        = 2'b01;
    localparam logic [1:0] OP_DOWN      = 2'b10;
    localparam logic [1:0] OP_UNTIL_OVF = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLR    = 2'd1,
        ST_RUN    = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_ctrl
// Brief    : Command-driven sequencer for an N-bit up/down counter; runs one
//            command at a time and reports final count and wrap status.
// Revision : 1.0 - initial release
// ============================================================================
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [N-1:0] cmd_len,
    input  logic         abort,
    output logic         count_en,
    output logic         count_clr,
    output logic         count_dir,
    input  logic [N-1:0] count,
    input  logic         overflow,
    output logic         done,
    output logic [N-1:0] done_count,
    output logic         done_ovf
);

    localparam logic [N-1:0] c_rem_one = {{(N-1){1'b0}}, 1'b1};

    state_t       r_state;
    state_t       w_next_state;
    logic [1:0]   r_op;
    logic [N-1:0] r_rem;
    logic         r_dir;
    logic         r_en_d;
    logic         r_ovf_seen;
    logic         r_done;
    logic [N-1:0] r_done_count;
    logic         r_done_ovf;

    logic w_accept;
    logic w_capture;
    logic w_en;
    logic w_clr;
    logic w_ready;
    logic w_ovf_hit;
    logic w_last;

    // A held overflow is stale unless the counter was enabled last cycle.
    assign w_ovf_hit = overflow & r_en_d;
    assign w_last    = (r_rem == c_rem_one);

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_en         = 1'b0;
        w_clr        = 1'b0;
        w_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (cmd_op == OP_CLEAR)
                        w_next_state = ST_CLR;
                    else if (cmd_op == OP_UNTIL_OVF)
                        w_next_state = ST_RUN;
                    else if (cmd_len == '0)
                        w_next_state = ST_SETTLE;
                    else
                        w_next_state = ST_RUN;
                end
            end
            ST_CLR: begin
                w_clr        = 1'b1;
                w_next_state = ST_SETTLE;
            end
            ST_RUN: begin
                if (r_op == OP_UNTIL_OVF) begin
                    if (w_ovf_hit) begin
                        w_capture    = 1'b1;
                        w_next_state = ST_IDLE;
                    end else if (abort) begin
                        w_next_state = ST_SETTLE;
                    end else begin
                        w_en = 1'b1;
                    end
                // An abort coinciding with the final enabled cycle completes normally.
                end else if (abort && !w_last) begin
                    w_next_state = ST_SETTLE;
                end else begin
                    w_en = 1'b1;
                    if (w_last)
                        w_next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_capture    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_CLEAR;
            r_rem        <= '0;
            r_dir        <= 1'b0;
            r_en_d       <= 1'b0;
            r_ovf_seen   <= 1'b0;
            r_done       <= 1'b0;
            r_done_count <= '0;
            r_done_ovf   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_en_d  <= w_en;
            r_done  <= w_capture;
            if (w_capture) begin
                r_done_count <= count;
                r_done_ovf   <= r_ovf_seen | w_ovf_hit;
            end
            if (w_accept) begin
                r_op       <= cmd_op;
                r_ovf_seen <= 1'b0;
                r_rem      <= (cmd_op == OP_UP || cmd_op == OP_DOWN) ? cmd_len : '0;
                if (cmd_op == OP_UP || cmd_op == OP_UNTIL_OVF)
                    r_dir <= 1'b1;
                else if (cmd_op == OP_DOWN)
                    r_dir <= 1'b0;
            end else begin
                if ((r_state == ST_RUN || r_state == ST_SETTLE) && w_ovf_hit)
                    r_ovf_seen <= 1'b1;
                if (r_state == ST_RUN && w_en && r_op != OP_UNTIL_OVF)
                    r_rem <= r_rem - c_rem_one;
            end
        end
    end

    assign cmd_ready  = rst_n & w_ready;
    assign count_en   = rst_n & w_en;
    assign count_clr  = rst_n & w_clr;
    assign count_dir  = r_dir;
    assign done       = r_done;
    assign done_count = r_done_count;
    assign done_ovf   = r_done_ovf;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_ctrl
// Brief    : Self-checking bench for counter_ctrl with an attached counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [N-1:0] cmd_len;
    logic         abort;
    logic         count_en;
    logic         count_clr;
    logic         count_dir;
    logic [N-1:0] count;
    logic         overflow;
    logic         done;
    logic [N-1:0] done_count;
    logic         done_ovf;

    int n_vec = 0;
    int n_err = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    counter_ctrl #(.N(N)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .abort      (abort),
        .count_en   (count_en),
        .count_clr  (count_clr),
        .count_dir  (count_dir),
        .count      (count),
        .overflow   (overflow),
        .done       (done),
        .done_count (done_count),
        .done_ovf   (done_ovf)
    );

    // Up/down counter attached to the sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (count_clr) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (count_en) begin
            if (count_dir) begin
                count    <= count + 1'b1;
                overflow <= (count == '1);
            end else begin
                count    <= count - 1'b1;
                overflow <= (count == '0);
            end
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one command and checks it against the arithmetic expectation.
    task automatic run_cmd(input logic [1:0] op, input int len, input int abort_at);
        int v, n, full, e_lat, e_cnt, e_ovf, e_clr;
        logic e_dir;
        int en_cnt, clr_cnt, dir_bad, done_cyc;
        en_cnt = 0; clr_cnt = 0; dir_bad = 0; done_cyc = 0;
        v     = m_cnt;
        e_clr = 0;
        e_dir = (op != OP_DOWN);
        case (op)
            OP_CLEAR: begin
                n = 0; e_clr = 1; e_lat = 2; e_cnt = 0; e_ovf = 0;
            end
            OP_UP, OP_DOWN: begin
                if (len == 0) begin
                    n = 0; e_lat = 1;
                end else if (abort_at >= 1 && abort_at < len) begin
                    n = abort_at - 1; e_lat = abort_at + 1;
                end else begin
                    n = len; e_lat = len + 1;
                end
                if (op == OP_UP) begin
                    e_cnt = (v + n) % 256;
                    e_ovf = (v + n > 255) ? 1 : 0;
                end else begin
                    e_cnt = (v - n + 256) % 256;
                    e_ovf = (n > v) ? 1 : 0;
                end
            end
            default: begin
                full = 256 - v;
                if (abort_at >= 1 && abort_at <= full) begin
                    n = abort_at - 1; e_lat = abort_at + 1; e_cnt = v + n; e_ovf = 0;
                end else begin
                    n = full; e_lat = full + 1; e_cnt = 0; e_ovf = 1;
                end
            end
        endcase

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len[N-1:0];
        @(negedge clk);
        check_eq("ready_before_accept", int'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_len   = N'($urandom);
        for (int c = 1; c <= 400; c++) begin
            abort = (c == abort_at);
            @(negedge clk);
            if (count_en) begin
                en_cnt++;
                if (count_dir !== e_dir) dir_bad++;
            end
            if (count_clr) clr_cnt++;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        check_eq("done_latency", done_cyc, e_lat + 1);
        check_eq("enable_cycles", en_cnt, n);
        check_eq("clear_pulses", clr_cnt, e_clr);
        check_eq("direction_errors", dir_bad, 0);
        check_eq("done_count", int'(done_count), e_cnt);
        check_eq("done_ovf", int'(done_ovf), e_ovf);
        check_eq("ready_in_done_cycle", int'(cmd_ready), 1);
        m_cnt = e_cnt;
        @(posedge clk); #1;
        check_eq("done_pulse_width", int'(done), 0);
    endtask

    initial begin
        int len, ab, v;
        logic [1:0] op;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_CLEAR; cmd_len = '0; abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", int'(cmd_ready), 0);
        check_eq("rst_count_en", int'(count_en), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_done_count", int'(done_count), 0);
        check_eq("rst_done_ovf", int'(done_ovf), 0);
        check_eq("rst_count_dir", int'(count_dir), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", int'(cmd_ready), 1);
        @(posedge clk); #1;

        run_cmd(OP_UP, 5, 0);
        run_cmd(OP_DOWN, 7, 0);
        run_cmd(OP_UP, 3, 0);
        run_cmd(OP_DOWN, 2, 0);
        run_cmd(OP_UP, 78, 0);
        run_cmd(OP_CLEAR, 0, 0);
        run_cmd(OP_DOWN, 0, 0);
        run_cmd(OP_UP, 250, 0);
        run_cmd(OP_UNTIL_OVF, 0, 0);
        run_cmd(OP_UP, 100, 10);

        // Reset in the middle of a run: enable must drop without a done.
        cmd_valid = 1'b1; cmd_op = OP_UP; cmd_len = 8'd50;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("run_before_rst", int'(count_en), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_drops_enable", int'(count_en), 0);
        check_eq("rst_drops_ready", int'(cmd_ready), 0);
        @(posedge clk); #1;
        check_eq("no_done_on_rst", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_mid_rst", int'(cmd_ready), 1);
        check_eq("no_done_after_rst", int'(done), 0);
        check_eq("no_enable_after_rst", int'(count_en), 0);
        m_cnt = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 30; i++) begin
            op  = 2'($urandom);
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 12));
            v   = (op == OP_UNTIL_OVF) ? (256 - m_cnt) : len;
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, v + 2)) : 0;
            run_cmd(op, len, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
